// File: rtl/popcnt_accum_pkg.sv
// Shared parameter defaults, lane code width and FSM state type for the popcount accumulator.
// Also hosts the width helper used to size the combinational beat value.
package popcnt_accum_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_BEAT_W = 10;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Width that holds LANES lane codes of value up to 7 without truncation.
    function automatic int beat_val_w(input int lanes);
        return $clog2(((1 << CNT_W) - 1) * lanes + 1);
    endfunction

endpackage

// File: rtl/popcnt_lane_sum.sv
// Adds the weighted 5-to-3 compressor results of all lanes into one beat value.
// Latency: purely combinational. Backpressure: none, no state.
// Lane codes 6 and 7 are summed as-is.
module popcnt_lane_sum
    import popcnt_accum_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int BV_W  = beat_val_w(LANES)
) (
    input  logic [CNT_W*LANES-1:0] in_cnt,
    output logic [BV_W-1:0]        beat_val
);

    always_comb begin
        beat_val = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_val = beat_val + BV_W'(in_cnt[CNT_W*i +: CNT_W]);
        end
    end

endmodule

// File: rtl/popcnt_accum.sv
// Accumulates per-beat popcounts over a frame with saturating sum/count and sticky overflow.
// Latency: result valid 1 cycle after the last beat is accepted.
// Backpressure: in_ready drops while a result is held; held until out_ready, no beat taken on consume.
module popcnt_accum
    import popcnt_accum_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int BEAT_W = DEF_BEAT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [CNT_W*LANES-1:0] in_cnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic [BEAT_W-1:0]      out_beats,
    output logic                   out_ovf
);

    localparam int BV_W  = beat_val_w(LANES);
    localparam int EXT_W = ((BV_W > ACC_W) ? BV_W : ACC_W) + 1;
    localparam logic [ACC_W-1:0]  ACC_MAX  = '1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [BEAT_W-1:0] beats;
    logic              ovf;

    logic [BV_W-1:0]   beat_val;
    logic              accept;
    logic [EXT_W-1:0]  sum_ext;
    logic [BEAT_W:0]   cnt_ext;
    logic              sum_sat;
    logic              cnt_sat;
    logic [ACC_W-1:0]  acc_nxt;
    logic [BEAT_W-1:0] beats_nxt;
    logic              ovf_nxt;

    popcnt_lane_sum #(
        .LANES (LANES),
        .BV_W  (BV_W)
    ) u_lane_sum (
        .in_cnt   (in_cnt),
        .beat_val (beat_val)
    );

    assign accept = in_valid && in_ready;

    // A frame's first beat starts from zero regardless of what acc holds.
    always_comb begin
        sum_ext   = '0;
        cnt_ext   = '0;
        sum_sat   = 1'b0;
        cnt_sat   = 1'b0;
        acc_nxt   = '0;
        beats_nxt = '0;
        ovf_nxt   = 1'b0;
        if (state == ACC) begin
            sum_ext = EXT_W'(acc) + EXT_W'(beat_val);
            cnt_ext = {1'b0, beats} + (BEAT_W+1)'(1);
        end else begin
            sum_ext = EXT_W'(beat_val);
            cnt_ext = (BEAT_W+1)'(1);
        end
        sum_sat   = (sum_ext > EXT_W'(ACC_MAX));
        cnt_sat   = cnt_ext[BEAT_W];
        acc_nxt   = sum_sat ? ACC_MAX : sum_ext[ACC_W-1:0];
        beats_nxt = cnt_sat ? BEAT_MAX : cnt_ext[BEAT_W-1:0];
        ovf_nxt   = ((state == ACC) && ovf) || sum_sat || cnt_sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            beats     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        acc   <= acc_nxt;
                        beats <= beats_nxt;
                        ovf   <= ovf_nxt;
                        if (in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        beats     <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    beats     <= '0;
                    ovf       <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_sum   = acc;
    assign out_beats = beats;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_popcnt_accum.sv
// Directed bench for popcnt_accum: default instance plus narrow-accumulator and narrow-counter instances.
module tb_popcnt_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [11:0] in_cnt;

    logic        rdy,  vld,  ovf;
    logic [15:0] sum;
    logic [9:0]  bts;
    logic        rdy6, vld6, ovf6;
    logic [5:0]  sum6;
    logic [9:0]  bts6;
    logic        rdyb, vldb, ovfb;
    logic [15:0] sumb;
    logic [1:0]  btsb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    popcnt_accum dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy), .in_last(in_last),
        .in_cnt(in_cnt), .out_valid(vld), .out_ready(out_ready), .out_sum(sum),
        .out_beats(bts), .out_ovf(ovf)
    );

    popcnt_accum #(.ACC_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy6), .in_last(in_last),
        .in_cnt(in_cnt), .out_valid(vld6), .out_ready(out_ready), .out_sum(sum6),
        .out_beats(bts6), .out_ovf(ovf6)
    );

    popcnt_accum #(.BEAT_W(2)) dutb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyb), .in_last(in_last),
        .in_cnt(in_cnt), .out_valid(vldb), .out_ready(out_ready), .out_sum(sumb),
        .out_beats(btsb), .out_ovf(ovfb)
    );

    function automatic logic [11:0] pk(input int l0, input int l1, input int l2, input int l3);
        pk = {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
    endfunction

    task automatic send(input logic [11:0] v, input logic last);
        in_valid = 1'b1;
        in_cnt   = v;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_cnt   = '0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_cnt = '0;
        #1;
        total++;
        if (vld !== 1'b0 || sum !== 16'd0 || bts !== 10'd0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got vld=%b sum=%0d beats=%0d ovf=%b want 0 0 0 0", vld, sum, bts, ovf);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (rdy !== 1'b1 || vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got rdy=%b vld=%b want 1 0", rdy, vld);
        end
    endtask

    task automatic test_single();
        send(pk(5, 5, 5, 5), 1'b1);
        total++;
        if (vld !== 1'b1 || sum !== 16'd20 || bts !== 10'd1 || ovf !== 1'b0 || rdy !== 1'b0) begin
            bad++;
            $display("FAIL single_beat got vld=%b sum=%0d beats=%0d ovf=%b rdy=%b want 1 20 1 0 0", vld, sum, bts, ovf, rdy);
        end
        consume();
        total++;
        if (vld !== 1'b0 || sum !== 16'd0 || bts !== 10'd0 || rdy !== 1'b1) begin
            bad++;
            $display("FAIL single_consume got vld=%b sum=%0d beats=%0d rdy=%b want 0 0 0 1", vld, sum, bts, rdy);
        end
    endtask

    task automatic test_gap();
        send(pk(1, 0, 2, 3), 1'b0);
        total++;
        if (vld !== 1'b0 || sum !== 16'd6 || bts !== 10'd1) begin
            bad++;
            $display("FAIL gap_first got vld=%b sum=%0d beats=%0d want 0 6 1", vld, sum, bts);
        end
        send(pk(0, 0, 0, 0), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (vld !== 1'b0 || sum !== 16'd6 || bts !== 10'd2 || rdy !== 1'b1) begin
            bad++;
            $display("FAIL gap_idle got vld=%b sum=%0d beats=%0d rdy=%b want 0 6 2 1", vld, sum, bts, rdy);
        end
        send(pk(5, 4, 3, 2), 1'b1);
        total++;
        if (vld !== 1'b1 || sum !== 16'd20 || bts !== 10'd3 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL gap_result got vld=%b sum=%0d beats=%0d ovf=%b want 1 20 3 0", vld, sum, bts, ovf);
        end
    endtask

    // Continues from the result left by test_gap; a beat is offered throughout the hold.
    task automatic test_hold();
        in_valid = 1'b1; in_cnt = pk(1, 1, 1, 1); in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if (vld !== 1'b1 || rdy !== 1'b0 || sum !== 16'd20 || bts !== 10'd3) begin
                bad++;
                $display("FAIL hold_cycle%0d got vld=%b rdy=%b sum=%0d beats=%0d want 1 0 20 3", c, vld, rdy, sum, bts);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (vld !== 1'b0 || rdy !== 1'b1 || sum !== 16'd0 || bts !== 10'd0) begin
            bad++;
            $display("FAIL hold_consume got vld=%b rdy=%b sum=%0d beats=%0d want 0 1 0 0", vld, rdy, sum, bts);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_cnt = '0;
        total++;
        if (vld !== 1'b1 || sum !== 16'd4 || bts !== 10'd1) begin
            bad++;
            $display("FAIL hold_next_frame got vld=%b sum=%0d beats=%0d want 1 4 1", vld, sum, bts);
        end
        consume();
    endtask

    task automatic test_saturate();
        send(pk(5, 5, 5, 5), 1'b0);
        send(pk(5, 5, 5, 5), 1'b0);
        send(pk(5, 5, 5, 5), 1'b0);
        total++;
        if (sum6 !== 6'd60 || ovf6 !== 1'b0 || btsb !== 2'd3 || ovfb !== 1'b0) begin
            bad++;
            $display("FAIL sat_pre got sum6=%0d ovf6=%b beatsb=%0d ovfb=%b want 60 0 3 0", sum6, ovf6, btsb, ovfb);
        end
        send(pk(5, 5, 5, 5), 1'b1);
        total++;
        if (vld6 !== 1'b1 || sum6 !== 6'd63 || bts6 !== 10'd4 || ovf6 !== 1'b1) begin
            bad++;
            $display("FAIL sat_acc got vld=%b sum=%0d beats=%0d ovf=%b want 1 63 4 1", vld6, sum6, bts6, ovf6);
        end
        total++;
        if (vld !== 1'b1 || sum !== 16'd80 || bts !== 10'd4 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL sat_wide got vld=%b sum=%0d beats=%0d ovf=%b want 1 80 4 0", vld, sum, bts, ovf);
        end
        total++;
        if (vldb !== 1'b1 || btsb !== 2'd3 || ovfb !== 1'b1 || sumb !== 16'd80) begin
            bad++;
            $display("FAIL sat_count got vld=%b beats=%0d ovf=%b sum=%0d want 1 3 1 80", vldb, btsb, ovfb, sumb);
        end
        consume();
        send(pk(0, 0, 0, 1), 1'b1);
        total++;
        if (vld6 !== 1'b1 || sum6 !== 6'd1 || bts6 !== 10'd1 || ovf6 !== 1'b0) begin
            bad++;
            $display("FAIL sat_clear got vld=%b sum=%0d beats=%0d ovf=%b want 1 1 1 0", vld6, sum6, bts6, ovf6);
        end
        total++;
        if (btsb !== 2'd1 || ovfb !== 1'b0) begin
            bad++;
            $display("FAIL sat_count_clear got beats=%0d ovf=%b want 1 0", btsb, ovfb);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        send(pk(1, 1, 1, 1), 1'b0);
        send(pk(1, 1, 1, 1), 1'b0);
        total++;
        if (sum !== 16'd8 || bts !== 10'd2) begin
            bad++;
            $display("FAIL mid_pre got sum=%0d beats=%0d want 8 2", sum, bts);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (vld !== 1'b0 || sum !== 16'd0 || bts !== 10'd0 || ovf !== 1'b0 || rdy !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset got vld=%b sum=%0d beats=%0d ovf=%b rdy=%b want 0 0 0 0 1", vld, sum, bts, ovf, rdy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(pk(1, 1, 1, 1), 1'b1);
        total++;
        if (vld !== 1'b1 || sum !== 16'd4 || bts !== 10'd1) begin
            bad++;
            $display("FAIL mid_after got vld=%b sum=%0d beats=%0d want 1 4 1", vld, sum, bts);
        end
        consume();
    endtask

    task automatic test_illegal();
        send(pk(7, 7, 7, 7), 1'b1);
        total++;
        if (vld !== 1'b1 || sum !== 16'd28 || bts !== 10'd1 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL illegal_code got vld=%b sum=%0d beats=%0d ovf=%b want 1 28 1 0", vld, sum, bts, ovf);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_hold();
        test_saturate();
        test_reset_mid();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/popcnt_accum.md
POPCNT_ACCUM -- requirements
Module: popcnt_accum

Interface
REQ-001 Parameter LANES, default 4, number of 5-to-3 compressor results accepted per beat.
REQ-002 Parameter ACC_W, default 16, width of the frame accumulator and out_sum.
REQ-003 Parameter BEAT_W, default 10, width of the beat counter and out_beats.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  a beat is presented on in_cnt.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_last  input  1  the presented beat closes the current frame.
REQ-009 in_cnt  input  3*LANES  per lane i: bit 3i+2 = cout (weight 4), bit 3i+1 = carry (weight 2), bit 3i = sum (weight 1).
REQ-010 out_valid  output  1  frame result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_sum  output  ACC_W  frame popcount total.
REQ-013 out_beats  output  BEAT_W  beats accepted in the frame.
REQ-014 out_ovf  output  1  accumulator or beat counter saturated during the frame.

Function
REQ-015 Lane value = 4*cout + 2*carry + sum; codes 6 and 7 are added arithmetically as-is, with no range check.
REQ-016 Beat value = unsigned sum of all LANES lane values, computed combinationally at full width (no truncation).
REQ-017 Beat acceptance occurs only on a cycle with in_valid=1 and in_ready=1; no other cycle alters the accumulator or the beat counter.
REQ-018 States: IDLE (accumulator and counter at 0), ACC (frame open), HOLD (result presented).
REQ-019 in_ready=1 in IDLE and ACC; in_ready=0 in HOLD.
REQ-020 IDLE with accepted beat, in_last=0: acc <= beat value, beats <= 1, go to ACC.
REQ-021 IDLE or ACC with accepted beat, in_last=1: acc and beats updated with this beat, go to HOLD; out_valid=1 on the next cycle (latency 1 from the final beat).
REQ-022 ACC with accepted beat, in_last=0: acc <= acc + beat value, beats <= beats + 1, stay in ACC.
REQ-023 Saturation: a sum exceeding 2^ACC_W-1 clamps to 2^ACC_W-1; a count exceeding 2^BEAT_W-1 clamps likewise; either event sets the sticky ovf flag for the frame.
REQ-024 HOLD: out_sum, out_beats and out_ovf stay stable while out_valid=1 and out_ready=0.
REQ-025 HOLD with out_ready=1: result consumed, go to IDLE and clear acc, beats and ovf on the same edge; out_valid=0 on the next cycle.
REQ-026 No beat is accepted on the consume cycle; the next frame's first beat is accepted no earlier than the following cycle.
REQ-027 out_valid is registered, and out_valid=1 only in HOLD.
REQ-028 out_sum, out_beats and out_ovf are driven directly from the registered accumulator, counter and flag.

Reset
REQ-029 rst_n=0 forces IDLE asynchronously and sets all of the following to 0: acc, beats, ovf, out_valid.
REQ-030 in_ready=1 after reset release.
REQ-031 Reset in mid-frame or in HOLD discards the partial or pending result with no output pulse.
REQ-032 Release of rst_n is synchronised to clk by the instantiating level, not inside this block.

Structure
REQ-033 A shared package holds LANES, ACC_W, BEAT_W, CNT_W=3 and the state enum {IDLE, ACC, HOLD}.
REQ-034 One sub-module is used: popcnt_lane_sum, purely combinational, converting in_cnt to the beat value.
REQ-035 All sequential logic sits in popcnt_accum.

Verification
REQ-036 Reset, then one beat with lanes {5,5,5,5}, in_last=1 -> next cycle out_valid=1, out_sum=20, out_beats=1, out_ovf=0.
REQ-037 Beats {1,0,2,3}, {0,0,0,0}, idle gap of 2 cycles with in_valid=0, then {5,4,3,2} with in_last=1 -> out_sum=20, out_beats=3.
REQ-038 Result held with out_ready=0 for 5 cycles -> out_valid=1, in_ready=0 and out_sum constant throughout; out_ready=1 -> IDLE; next frame {1,1,1,1} last -> out_sum=4.
REQ-039 ACC_W=6, four beats of {5,5,5,5}, the last with in_last=1 -> out_sum=63, out_beats=4, out_ovf=1; the following frame with {0,0,0,1} last -> out_sum=1, out_ovf=0.
REQ-040 rst_n pulsed low after 2 accepted beats -> out_valid=0 and all outputs 0 immediately; then {1,1,1,1} last -> out_sum=4, out_beats=1.
REQ-041 Illegal code 7 on all lanes, single beat with in_last=1 -> out_sum=28.
